// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 memory stage: data-cache request/response sequencing with store lane formatting.
// Forwards raw load words to writeback; load masking and sign extension happen downstream.
module mem_stage #(
  parameter int XLEN   = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_rr,
  input  logic              ex_mem_we,
  input  logic              ex_do_jump,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [XLEN-1:0]   dcache_addr,
  output logic              dcache_re,
  output logic [MASK_W-1:0] dcache_we,
  output logic [XLEN-1:0]   dcache_din,
  input  logic              dcache_resp_valid,
  input  logic [XLEN-1:0]   dcache_dout,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [XLEN-1:0]   wb_alu_result,
  output logic [XLEN-1:0]   wb_dcache_dout,
  output logic [2:0]        wb_funct3,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_we,
  output logic              wb_mem_rr,
  output logic              wb_do_jump,
  output logic              wb_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_rr;
    logic            do_jump;
  } fields_t;

  state_t            state;
  fields_t           ex_f;
  fields_t           hold;
  fields_t           wb_q;
  logic              hold_store;
  logic              mem_op;
  logic              misaligned;
  logic [XLEN-1:0]   st_din;
  logic [MASK_W-1:0] st_we;

  // A request with both load and store flags is treated as a store.
  always_comb begin
    ex_f.pc      = ex_pc;
    ex_f.alu     = ex_alu_result;
    ex_f.funct3  = ex_funct3;
    ex_f.rd      = ex_rd;
    ex_f.reg_we  = ex_reg_we;
    ex_f.mem_rr  = ex_mem_rr & ~ex_mem_we;
    ex_f.do_jump = ex_do_jump;
  end

  assign mem_op     = ex_mem_rr | ex_mem_we;
  assign misaligned = mem_op &
                      (((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                       ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00)));

  always_comb begin
    st_din = ex_rs2;
    st_we  = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_din = {4{ex_rs2[7:0]}};
        st_we  = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        st_din = {2{ex_rs2[15:0]}};
        st_we  = ex_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_din = ex_rs2;
        st_we  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      hold             <= '0;
      hold_store       <= 1'b0;
      wb_q             <= '0;
      wb_valid         <= 1'b0;
      wb_dcache_dout   <= '0;
      wb_misaligned    <= 1'b0;
      dcache_req_valid <= 1'b0;
      dcache_addr      <= '0;
      dcache_re        <= 1'b0;
      dcache_we        <= '0;
      dcache_din       <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            hold       <= ex_f;
            hold_store <= ex_mem_we;
            if (misaligned) begin
              wb_valid      <= 1'b1;
              wb_q          <= ex_f;
              wb_q.reg_we   <= 1'b0;
              wb_misaligned <= 1'b1;
            end else if (mem_op) begin
              state            <= REQ;
              dcache_req_valid <= 1'b1;
              dcache_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
              dcache_re        <= ~ex_mem_we;
              dcache_we        <= ex_mem_we ? st_we : '0;
              dcache_din       <= st_din;
            end else begin
              wb_valid      <= 1'b1;
              wb_q          <= ex_f;
              wb_misaligned <= 1'b0;
            end
          end
        end
        REQ: begin
          if (dcache_req_ready) begin
            dcache_req_valid <= 1'b0;
            dcache_re        <= 1'b0;
            dcache_we        <= '0;
            if (hold_store) begin
              state         <= IDLE;
              wb_valid      <= 1'b1;
              wb_q          <= hold;
              wb_misaligned <= 1'b0;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (dcache_resp_valid) begin
            state          <= IDLE;
            wb_valid       <= 1'b1;
            wb_q           <= hold;
            wb_dcache_dout <= dcache_dout;
            wb_misaligned  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ex_ready      = (state == IDLE);
  assign wb_pc         = wb_q.pc;
  assign wb_alu_result = wb_q.alu;
  assign wb_funct3     = wb_q.funct3;
  assign wb_rd         = wb_q.rd;
  assign wb_reg_we     = wb_valid & wb_q.reg_we;
  assign wb_mem_rr     = wb_q.mem_rr;
  assign wb_do_jump    = wb_q.do_jump;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_result, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_rr, ex_mem_we, ex_do_jump;
  logic        dcache_req_valid, dcache_req_ready;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic        dcache_resp_valid;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_alu_result, wb_dcache_dout;
  logic [2:0]  wb_funct3;
  logic [4:0]  wb_rd;
  logic        wb_reg_we, wb_mem_rr, wb_do_jump, wb_misaligned;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr), .ex_mem_we(ex_mem_we), .ex_do_jump(ex_do_jump),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we), .dcache_din(dcache_din),
    .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result),
    .wb_dcache_dout(wb_dcache_dout), .wb_funct3(wb_funct3), .wb_rd(wb_rd),
    .wb_reg_we(wb_reg_we), .wb_mem_rr(wb_mem_rr), .wb_do_jump(wb_do_jump),
    .wb_misaligned(wb_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic rwe, input logic rr, input logic mwe);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_alu_result = alu;
    ex_rs2        = rs2;
    ex_funct3     = f3;
    ex_rd         = rd;
    ex_reg_we     = rwe;
    ex_mem_rr     = rr;
    ex_mem_we     = mwe;
    ex_do_jump    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    ex_valid = 1'b0; ex_pc = '0; ex_alu_result = '0; ex_rs2 = '0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_we = 1'b0; ex_mem_rr = 1'b0; ex_mem_we = 1'b0; ex_do_jump = 1'b0;
    dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_dout = '0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_valid", dcache_req_valid, 0);
    check("rst_we", dcache_we, 0);
    check("rst_re", dcache_re, 0);
    check("rst_ex_ready", ex_ready, 1);
    check("rst_wb_pc", wb_pc, 0);

    // ALU op
    drive(32'h100, 32'h1234, 0, 3'd0, 5'd5, 1, 0, 0);
    step();
    ex_valid = 1'b0;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_alu", wb_alu_result, 32'h1234);
    check("alu_wb_rd", wb_rd, 5);
    check("alu_wb_reg_we", wb_reg_we, 1);
    check("alu_wb_pc", wb_pc, 32'h100);
    check("alu_ex_ready", ex_ready, 1);
    step();
    check("alu_pulse_end", wb_valid, 0);
    check("alu_reg_we_gated", wb_reg_we, 0);
    check("alu_hold_value", wb_alu_result, 32'h1234);

    // SB with a stalled cache
    drive(32'h104, 32'h1003, 32'hAABBCCDD, 3'b000, 5'd0, 0, 0, 1);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sb_req_valid", dcache_req_valid, 1);
      check("sb_addr", dcache_addr, 32'h1000);
      check("sb_we", dcache_we, 4'b1000);
      check("sb_din", dcache_din, 32'hDDDDDDDD);
      check("sb_ex_ready", ex_ready, 0);
      check("sb_wb_idle", wb_valid, 0);
      step();
    end
    dcache_req_ready = 1'b1;
    check("sb_req_valid_at_accept", dcache_req_valid, 1);
    step();
    dcache_req_ready = 1'b0;
    check("sb_wb_valid", wb_valid, 1);
    check("sb_req_dropped", dcache_req_valid, 0);
    check("sb_we_cleared", dcache_we, 0);
    check("sb_wb_pc", wb_pc, 32'h104);
    check("sb_ex_ready_back", ex_ready, 1);

    // SH to upper half, accepted immediately
    dcache_req_ready = 1'b1;
    drive(32'h106, 32'h1002, 32'hAABBCCDD, 3'b001, 5'd0, 0, 0, 1);
    step();
    ex_valid = 1'b0;
    check("sh_we", dcache_we, 4'b1100);
    check("sh_din", dcache_din, 32'hCCDDCCDD);
    check("sh_addr", dcache_addr, 32'h1000);
    step();
    check("sh_wb_valid", wb_valid, 1);

    // LW, response arriving 4 cycles after accept
    drive(32'h108, 32'h2000, 0, 3'b010, 5'd7, 1, 1, 0);
    step();
    ex_valid = 1'b0;
    check("lw_req_valid", dcache_req_valid, 1);
    check("lw_re", dcache_re, 1);
    check("lw_we", dcache_we, 0);
    check("lw_addr", dcache_addr, 32'h2000);
    dcache_resp_valid = 1'b1;
    dcache_dout = 32'h11111111;
    step();
    dcache_resp_valid = 1'b0;
    dcache_req_ready = 1'b0;
    check("lw_accept_resp_ignored", wb_valid, 0);
    check("lw_req_dropped", dcache_req_valid, 0);
    check("lw_ex_ready_wait", ex_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_waiting", wb_valid, 0);
    end
    dcache_resp_valid = 1'b1;
    dcache_dout = 32'hCAFEF00D;
    step();
    dcache_resp_valid = 1'b0;
    check("lw_wb_valid", wb_valid, 1);
    check("lw_wb_dout", wb_dcache_dout, 32'hCAFEF00D);
    check("lw_wb_mem_rr", wb_mem_rr, 1);
    check("lw_wb_rd", wb_rd, 7);
    check("lw_wb_reg_we", wb_reg_we, 1);
    check("lw_wb_funct3", wb_funct3, 3'b010);

    // Misaligned SW
    drive(32'h10C, 32'h2002, 32'h55, 3'b010, 5'd3, 1, 0, 1);
    step();
    ex_valid = 1'b0;
    check("mis_sw_req", dcache_req_valid, 0);
    check("mis_sw_wb_valid", wb_valid, 1);
    check("mis_sw_flag", wb_misaligned, 1);
    check("mis_sw_reg_we", wb_reg_we, 0);
    check("mis_sw_ex_ready", ex_ready, 1);

    // Misaligned LH
    drive(32'h110, 32'h3001, 0, 3'b001, 5'd4, 1, 1, 0);
    step();
    ex_valid = 1'b0;
    check("mis_lh_req", dcache_req_valid, 0);
    check("mis_lh_flag", wb_misaligned, 1);
    check("mis_lh_reg_we", wb_reg_we, 0);

    // Back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      drive(32'h200 + 4 * i, 32'h10 + i, 0, 3'd0, 5'(i + 1), 1, 0, 0);
      step();
      check("b2b_wb_valid", wb_valid, 1);
      check("b2b_wb_alu", wb_alu_result, 32'h10 + i);
      check("b2b_misaligned_clear", wb_misaligned, 0);
    end
    ex_valid = 1'b0;
    step();
    check("b2b_end", wb_valid, 0);

    // Reset during WAIT_RESP
    dcache_req_ready = 1'b1;
    drive(32'h300, 32'h3000, 0, 3'b010, 5'd9, 1, 1, 0);
    step();
    ex_valid = 1'b0;
    step();
    dcache_req_ready = 1'b0;
    check("rstw_in_wait", ex_ready, 0);
    reset_n = 1'b0;
    #1;
    check("rstw_async_ready", ex_ready, 1);
    step();
    reset_n = 1'b1;
    dcache_resp_valid = 1'b1;
    dcache_dout = 32'hDEADBEEF;
    step();
    dcache_resp_valid = 1'b0;
    check("rstw_wb_valid", wb_valid, 0);
    check("rstw_ex_ready", ex_ready, 1);
    check("rstw_req_valid", dcache_req_valid, 0);
    check("rstw_dout_ignored", wb_dcache_dout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RV32 pipeline, sitting directly upstream of the writeback stage.
- Accepts one instruction at a time from execute and issues data-cache loads/stores with byte-lane formatting.
- Stalls execute until the access completes, then presents registered results to writeback: pc, alu_result, raw dcache_dout, funct3, reg_we, mem_rr, do_jump, rd.
- Load masking/sign extension stays in writeback; this block forwards the raw 32-bit word.

Parameters:
- XLEN, 32, datapath and address width.
- MASK_W, 4, store byte-enable width (XLEN/8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept; a transfer occurs when ex_valid & ex_ready.
- ex_pc  in  32  instruction pc.
- ex_alu_result  in  32  ALU result / effective byte address.
- ex_rs2  in  32  store data.
- ex_funct3  in  3  load/store size code.
- ex_rd  in  5  destination register.
- ex_reg_we, ex_mem_rr, ex_mem_we, ex_do_jump  in  1 each  register write, load, store, jump flags.
- dcache_req_valid  out  1  request valid.
- dcache_req_ready  in  1  cache accepts request this cycle.
- dcache_addr  out  32  word-aligned address {alu[31:2],2'b00}.
- dcache_re  out  1  read request.
- dcache_we  out  4  byte write enables.
- dcache_din  out  32  lane-replicated store data.
- dcache_resp_valid  in  1  load data valid.
- dcache_dout  in  32  load data.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_pc, wb_alu_result, wb_dcache_dout  out  32 each  registered results.
- wb_funct3  out  3  registered funct3.
- wb_rd  out  5  registered destination register.
- wb_reg_we, wb_mem_rr, wb_do_jump  out  1 each  registered flags; wb_reg_we forced 0 when wb_valid=0.
- wb_misaligned  out  1  access was misaligned and dropped.

Behaviour:
- Reset state: FSM IDLE; all wb_* outputs 0; dcache_req_valid=0; dcache_we=0; dcache_re=0. ex_ready=1 after reset deassertion.
- FSM states: IDLE, REQ, WAIT_RESP. ex_ready = (state==IDLE). A transfer captures every ex_* field into an internal holding register.
- IDLE transfer, no mem op (mem_rr=mem_we=0): stay IDLE; wb_valid=1 next cycle. Latency 1, throughput 1 per cycle.
- IDLE transfer, misaligned access (SH/LH/LHU with alu[0]=1, or SW/LW with alu[1:0]!=0): no cache request; stay IDLE; next cycle wb_valid=1, wb_misaligned=1, wb_reg_we=0.
- IDLE transfer, load or store: go to REQ.
- REQ: dcache_req_valid=1; address and data driven from the holding register and held stable until dcache_req_ready.
  - On accept with a store: go to IDLE; wb_valid=1 next cycle.
  - On accept with a load: go to WAIT_RESP.
- WAIT_RESP: on dcache_resp_valid, capture dcache_dout into wb_dcache_dout, go to IDLE, wb_valid=1 next cycle. dcache_resp_valid in the same cycle as the accept is not sampled.
- dcache_resp_valid outside WAIT_RESP is ignored.
- Store formatting:
  - SB (000): din={4{rs2[7:0]}}, we=4'b0001<<alu[1:0].
  - SH (001): din={2{rs2[15:0]}}, we=alu[1]?4'b1100:4'b0011.
  - SW (010): din=rs2, we=4'b1111.
- Loads: dcache_re=1, dcache_we=0.
- If both ex_mem_rr and ex_mem_we are set, the instruction is treated as a store.
- wb_* fields other than wb_valid hold their last values between pulses.
- reset_n asserted mid-access: immediate return to IDLE; any in-flight request is abandoned; a later response is ignored.

Test Plan:
- ALU op: ex_alu_result=0x1234, ex_rd=5, ex_reg_we=1 accepted at cycle N -> wb_valid=1 at N+1, wb_alu_result=0x1234, wb_rd=5, ex_ready stays 1.
- SB: addr 0x1003, rs2=0xAABBCCDD, req_ready held 0 for 3 cycles -> req, addr and data held stable; dcache_addr=0x1000, we=4'b1000, din=0xDDDDDDDD; ex_ready=0 until accept; wb_valid one cycle after accept.
- LW: addr 0x2000, req_ready=1 immediately, resp_valid 4 cycles later with dout=0xCAFEF00D -> wb_valid one cycle after resp, wb_dcache_dout=0xCAFEF00D, wb_mem_rr=1.
- Misaligned SW: addr 0x2002 -> no dcache_req_valid; next cycle wb_valid=1, wb_misaligned=1, wb_reg_we=0.
- Back-to-back ALU ops on 4 consecutive cycles -> 4 consecutive wb_valid pulses in order.
- reset_n low during WAIT_RESP, then a resp_valid pulse -> state IDLE, wb_valid stays 0, ex_ready=1.
